banc_reg_param: RTL and testbench



---
 rtl/banc_reg_param.sv | 102 ++++++++++
 tb/tb_banc_reg_param.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/banc_reg_param.sv
// Parametrised multi-read-port register bank: registered reads, write-first bypass, and a hardware clear sequencer.
// Compile-time option BREG_ZERO_REG_EN hardwires entry 0 to zero.
module banc_reg_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     RdEn,
  input  logic [NUM_RD*ADDR_W-1:0] RAddr,
  output logic [NUM_RD*DATA_W-1:0] RData,
  output logic                     RdValid,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WAddr,
  input  logic [DATA_W-1:0]        WData,
  output logic                     Ready,
  output logic                     WrDropped
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
`ifdef BREG_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  // DEPTH may equal 2**ADDR_W, so the bound is compared one bit wider.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                clr_we;
  logic                wr_acc_p0;
  logic                wr_drop_p0;
  logic [NUM_RD*DATA_W-1:0] rd_val_p0;
  logic [DATA_W-1:0]   banco [DEPTH];

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    if (state == CLEAR) begin
      clr_we      = Rst_n;
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST_IDX) state_nxt = RUN;
    end
  end

  assign wr_acc_p0  = Rst_n && WrEn && (state == RUN) && in_range(WAddr) && !is_zero_reg(WAddr);
  assign wr_drop_p0 = WrEn && !is_zero_reg(WAddr) && ((state == CLEAR) || !in_range(WAddr));

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    assign ra = RAddr[g*ADDR_W +: ADDR_W];
    always_comb begin
      val = banco[ra[IDX_W-1:0]];
      if ((state == CLEAR) || !in_range(ra) || is_zero_reg(ra)) val = '0;
      else if (wr_acc_p0 && (WAddr == ra)) val = WData;
    end
    assign rd_val_p0[g*DATA_W +: DATA_W] = val;
  end

  // p0 -> p1: control and registered read data
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      Ready     <= 1'b0;
      RdValid   <= 1'b0;
      WrDropped <= 1'b0;
      RData     <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      Ready     <= (state_nxt == RUN);
      RdValid   <= RdEn && Ready;
      WrDropped <= wr_drop_p0;
      if (RdEn) RData <= rd_val_p0;
    end
  end

  // p0 -> array: the clear sequencer and the write port never overlap
  always_ff @(posedge Clk) begin
    if (clr_we)
      banco[clr_cnt[IDX_W-1:0]] <= '0;
    else if (wr_acc_p0)
      banco[WAddr[IDX_W-1:0]] <= WData;
  end

endmodule

// File: tb/tb_banc_reg_param.sv
// Directed bench for banc_reg_param: DEPTH=32 and DEPTH=24 instances share one stimulus stream.
module tb_banc_reg_param;

  logic        Clk = 1'b0;
  logic        Rst_n, RdEn, WrEn;
  logic [9:0]  RAddr;
  logic [4:0]  WAddr;
  logic [31:0] WData;
  logic [63:0] RData32, RData24;
  logic        RdValid32, RdValid24, Ready32, Ready24, WrDropped32, WrDropped24;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  banc_reg_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2)) dut32 (
    .Clk(Clk), .Rst_n(Rst_n), .RdEn(RdEn), .RAddr(RAddr), .RData(RData32),
    .RdValid(RdValid32), .WrEn(WrEn), .WAddr(WAddr), .WData(WData),
    .Ready(Ready32), .WrDropped(WrDropped32));

  banc_reg_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .NUM_RD(2)) dut24 (
    .Clk(Clk), .Rst_n(Rst_n), .RdEn(RdEn), .RAddr(RAddr), .RData(RData24),
    .RdValid(RdValid24), .WrEn(WrEn), .WAddr(WAddr), .WData(WData),
    .Ready(Ready24), .WrDropped(WrDropped24));

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        vld;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        c24;
    logic        drop24;
  } vec_t;

  vec_t vt [12];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    logic [31:0] z0;
    int cnt;
`ifdef BREG_ZERO_REG_EN
    z0 = 32'h0;
`else
    z0 = 32'h55AA55AA;
`endif
    vt[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd4,  32'h0BADF00D, 1'b0, 5'd0,  5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  5'd4,  1'b1, 32'h12345678, 32'h0BADF00D, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd7,  1'b1, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  5'd7,  1'b1, 32'h11111111, 32'h11111111, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 32'h11111111, 32'h11111111, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 5'd30, 32'hCAFEF00D, 1'b1, 5'd30, 5'd1,  1'b1, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 5'd0,  1'b1, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0};
    vt[9]  = '{1'b1, 5'd0,  32'h55AA55AA, 1'b1, 5'd0,  5'd31, 1'b1, z0,           32'h0,        1'b0, 1'b0};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd4,  1'b1, z0,           32'h0BADF00D, 1'b0, 1'b0};
    vt[11] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 5'd30, 1'b1, 32'h80000001, 32'hCAFEF00D, 1'b0, 1'b0};

    Rst_n = 1'b0; RdEn = 1'b0; WrEn = 1'b0; RAddr = '0; WAddr = '0; WData = '0;
    repeat (3) step();
    chk("rst_rdata0", RData32[31:0], 32'h0);
    chk("rst_rdata1", RData32[63:32], 32'h0);
    chk("rst_rdvalid", 32'(RdValid32), 32'h0);
    chk("rst_ready", 32'(Ready32), 32'h0);
    chk("rst_wrdropped", 32'(WrDropped32), 32'h0);

    // Partial clear, then reset again mid-sequence.
    Rst_n = 1'b1;
    repeat (10) step();
    chk("midclear_ready_before", 32'(Ready32), 32'h0);
    Rst_n = 1'b0;
    step();
    chk("midclear_ready_rst", 32'(Ready32), 32'h0);

    // Full clear with a write and reads issued during the clear.
    Rst_n = 1'b1; WrEn = 1'b1; WAddr = 5'd5; WData = 32'hAAAA5555;
    RdEn = 1'b1; RAddr = {5'd5, 5'd5};
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("clear_ready32_k%0d", k), 32'(Ready32), 32'(k == 32));
      chk($sformatf("clear_ready24_k%0d", k), 32'(Ready24), 32'(k >= 24));
      chk($sformatf("clear_rdvalid_k%0d", k), 32'(RdValid32), 32'h0);
      chk($sformatf("clear_wrdropped_k%0d", k), 32'(WrDropped32), 32'(k == 1));
      if (k == 1) WrEn = 1'b0;
    end

    for (int j = 0; j < 16; j++) begin
      RAddr = {5'(2*j + 1), 5'(2*j)};
      step();
      chk($sformatf("zero_vld_%0d", j), 32'(RdValid32), 32'h1);
      chk($sformatf("zero_r%0d", 2*j), RData32[31:0], 32'h0);
      chk($sformatf("zero_r%0d", 2*j + 1), RData32[63:32], 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      WrEn = vt[i].wr; WAddr = vt[i].wa; WData = vt[i].wd;
      RdEn = vt[i].rd; RAddr = {vt[i].ra1, vt[i].ra0};
      step();
      chk($sformatf("vec%0d_vld", i), 32'(RdValid32), 32'(vt[i].vld));
      chk($sformatf("vec%0d_r0", i), RData32[31:0], vt[i].r0);
      chk($sformatf("vec%0d_r1", i), RData32[63:32], vt[i].r1);
      chk($sformatf("vec%0d_drop", i), 32'(WrDropped32), 32'h0);
      if (vt[i].c24) begin
        chk($sformatf("vec%0d_d24_drop", i), 32'(WrDropped24), 32'(vt[i].drop24));
        chk($sformatf("vec%0d_d24_r0", i), RData24[31:0], 32'h0);
      end
    end
    WrEn = 1'b0; RdEn = 1'b0;

    // Reset in RUN overrides a simultaneous read and write.
    Rst_n = 1'b0; RdEn = 1'b1; WrEn = 1'b1; WAddr = 5'd9; WData = 32'hFFFFFFFF;
    RAddr = {5'd7, 5'd3};
    step();
    chk("run_rst_rdvalid", 32'(RdValid32), 32'h0);
    chk("run_rst_r0", RData32[31:0], 32'h0);
    chk("run_rst_r1", RData32[63:32], 32'h0);
    chk("run_rst_wrdropped", 32'(WrDropped32), 32'h0);
    chk("run_rst_ready", 32'(Ready32), 32'h0);

    Rst_n = 1'b1; WrEn = 1'b0; RdEn = 1'b0;
    cnt = 0;
    while (!Ready32 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("reclear_cycles", 32'(cnt), 32'd32);

    RdEn = 1'b1; RAddr = {5'd7, 5'd3};
    step();
    chk("reclear_vld", 32'(RdValid32), 32'h1);
    chk("reclear_r3", RData32[31:0], 32'h0);
    chk("reclear_r7", RData32[63:32], 32'h0);
    RdEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
